// File: rtl/button_clicker.sv
// Mouse-click decoder for a horizontal row of N_BTN buttons: debounce, arm on press, click on release.
// Optional hover output is enabled by defining BUTTON_HOVER_EN.
module button_clicker #(
    parameter int N_BTN    = 3,
    parameter int X0       = 342,
    parameter int PITCH    = 120,
    parameter int BTN_W    = 100,
    parameter int Y0       = 668,
    parameter int BTN_H    = 50,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      mouse_x,
    input  logic [11:0]      mouse_y,
    input  logic             left_mouse,
    input  logic [N_BTN-1:0] btn_enable,
    output logic [N_BTN-1:0] click,
    output logic [N_BTN-1:0] pressed
`ifdef BUTTON_HOVER_EN
    ,
    output logic [N_BTN-1:0] hover
`endif
);

    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [N_BTN-1:0] ONE = N_BTN'(1);

    generate
        if (X0 + (N_BTN - 1) * PITCH + BTN_W > 4095) begin : g_x_range
            $error("button_clicker: rightmost button edge exceeds 4095");
        end
        if (Y0 + BTN_H > 4095) begin : g_y_range
            $error("button_clicker: button bottom edge exceeds 4095");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    logic [11:0]      x_r, y_r;
    logic             left_r;
    logic             db_left_r, db_prev_r;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [N_BTN-1:0] click_r, click_s;
    logic [N_BTN-1:0] pressed_r, pressed_s;

    logic [N_BTN-1:0] hit_s, en_hit_s;
    logic [IDX_W-1:0] hit_idx_s;
    logic             hit_any_s, idx_hit_s, idx_en_s;
    logic             rise_s, fall_s;

    // Input registers: everything downstream sees only these values
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= 12'd0;
            y_r    <= 12'd0;
            left_r <= 1'b0;
        end else begin
            x_r    <= mouse_x;
            y_r    <= mouse_y;
            left_r <= left_mouse;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            db_left_r <= 1'b0;
            db_prev_r <= 1'b0;
        end else begin
            db_prev_r <= db_left_r;
            if (left_r == db_left_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r     <= '0;
                db_left_r <= left_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign rise_s = db_left_r & ~db_prev_r;
    assign fall_s = ~db_left_r & db_prev_r;

    // Inclusive rectangle hit test in 13-bit unsigned arithmetic
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < N_BTN; i++) begin
            hit_s[i] = ({1'b0, x_r} >= 13'(X0 + i * PITCH)) &&
                       ({1'b0, x_r} <= 13'(X0 + i * PITCH + BTN_W)) &&
                       ({1'b0, y_r} >= 13'(Y0)) &&
                       ({1'b0, y_r} <= 13'(Y0 + BTN_H));
        end
    end

    assign en_hit_s  = hit_s & btn_enable;
    assign hit_any_s = |en_hit_s;

    // Lowest enabled index under the cursor wins
    always_comb begin
        hit_idx_s = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            hit_idx_s = en_hit_s[i] ? IDX_W'(i) : hit_idx_s;
        end
    end

    assign idx_hit_s = hit_s[idx_r];
    assign idx_en_s  = btn_enable[idx_r];

    // Next state, captured index and output values
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        click_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s && hit_any_s) begin
                    state_s = ST_ARMED;
                    idx_s   = hit_idx_s;
                end else if (rise_s) begin
                    state_s = ST_DEAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (fall_s) begin
                    state_s = ST_IDLE;
                    click_s = (idx_hit_s && idx_en_s) ? (ONE << idx_r) : '0;
                end else if (!idx_en_s) begin
                    state_s = ST_DEAD;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_DEAD: begin
                if (fall_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DEAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // pressed follows the state being entered so it appears together with arming
        if (state_s == ST_ARMED && hit_s[idx_s]) begin
            pressed_s = ONE << idx_s;
        end else begin
            pressed_s = '0;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            click_r   <= '0;
            pressed_r <= '0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            click_r   <= click_s;
            pressed_r <= pressed_s;
        end
    end

    assign click   = click_r;
    assign pressed = pressed_r;

`ifdef BUTTON_HOVER_EN
    logic [N_BTN-1:0] hover_r;

    // Hover tracks the enabled button under the cursor, independent of the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            hover_r <= '0;
        end else begin
            hover_r <= hit_any_s ? (ONE << hit_idx_s) : '0;
        end
    end

    assign hover = hover_r;
`endif

endmodule

// File: tb/tb_button_clicker.sv
// Self-checking bench for button_clicker with default parameters.
// Expected outputs are queued per cycle when stimulus is driven and popped after the clock edge.
module tb_button_clicker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mouse_x = 12'd0;
    logic [11:0] mouse_y = 12'd0;
    logic        left_mouse = 1'b0;
    logic [2:0]  btn_enable = 3'b111;
    logic [2:0]  click, pressed;
`ifdef BUTTON_HOVER_EN
    logic [2:0]  hover;
`endif

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    logic [2:0] hov_q[$];

    button_clicker dut (
        .clk        (clk),
        .rst        (rst),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .left_mouse (left_mouse),
        .btn_enable (btn_enable),
        .click      (click),
        .pressed    (pressed)
`ifdef BUTTON_HOVER_EN
        ,
        .hover      (hover)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic tick(input logic [11:0] x, input logic [11:0] y, input logic lm,
                        input logic [2:0] en, input logic r);
        mouse_x    = x;
        mouse_y    = y;
        left_mouse = lm;
        btn_enable = en;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick(12'd0, 12'd0, 1'b0, 3'b111, 1'b1);
        tick(12'd0, 12'd0, 1'b0, 3'b111, 1'b1);
    endtask

    task automatic test_reset();
        logic [5:0] obs_v, exp_v;
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back(6'b000000);
            tick(12'd400, 12'd690, (c < 2), 3'b111, (c < 2));
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_click();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ec, ep;
        settle();
        for (int c = 0; c < 25; c++) begin
            ep = (c >= 5 && c <= 14) ? 3'b001 : 3'b000;
            ec = (c == 15) ? 3'b001 : 3'b000;
            exp_q.push_back({ec, ep});
            tick(12'd400, 12'd690, (c < 10), 3'b111, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL click c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_drag_off();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ep;
        settle();
        for (int c = 0; c < 25; c++) begin
            ep = (c >= 5 && c <= 8) ? 3'b010 : 3'b000;
            exp_q.push_back({3'b000, ep});
            if (c < 8) tick(12'd462, 12'd668, (c < 15), 3'b111, 1'b0);
            else       tick(12'd600, 12'd700, (c < 15), 3'b111, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL drag_off c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reenter();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ec, ep;
        logic [11:0] x;
        settle();
        for (int c = 0; c < 26; c++) begin
            ep = ((c >= 5 && c <= 8) || (c >= 11 && c <= 20)) ? 3'b010 : 3'b000;
            ec = (c == 21) ? 3'b010 : 3'b000;
            x  = (c == 8 || c == 9) ? 12'd700 : 12'd500;
            exp_q.push_back({ec, ep});
            tick(x, 12'd690, (c < 16), 3'b111, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reenter c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_dead();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ec, ep;
        logic [11:0] x;
        logic lm;
        settle();
        for (int c = 0; c < 50; c++) begin
            ep = (c >= 30 && c <= 39) ? 3'b010 : 3'b000;
            ec = (c == 40) ? 3'b010 : 3'b000;
            x  = (c < 6) ? 12'd450 : 12'd500;
            lm = (c < 10) || (c >= 25 && c < 35);
            exp_q.push_back({ec, ep});
            tick(x, 12'd690, lm, 3'b111, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL dead c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ec, ep;
        logic lm;
        settle();
        // 3-cycle pulse is filtered; 4-cycle pulse starting at c=20 is accepted
        for (int c = 0; c < 35; c++) begin
            ep = (c >= 25 && c <= 28) ? 3'b001 : 3'b000;
            ec = (c == 29) ? 3'b001 : 3'b000;
            lm = (c < 3) || (c >= 20 && c < 24);
            exp_q.push_back({ec, ep});
            tick(12'd400, 12'd690, lm, 3'b111, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL glitch c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_disabled();
        logic [5:0] obs_v, exp_v;
        settle();
        for (int c = 0; c < 20; c++) begin
            exp_q.push_back(6'b000000);
            tick(12'd400, 12'd690, (c < 8), 3'b110, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL disabled c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ep;
        settle();
        for (int c = 0; c < 25; c++) begin
            ep = (c >= 5 && c <= 7) ? 3'b100 : 3'b000;
            exp_q.push_back({3'b000, ep});
            tick(12'd630, 12'd700, (c < 12), (c < 8) ? 3'b111 : 3'b011, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL enable_drop c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ep;
        settle();
        for (int c = 0; c < 25; c++) begin
            ep = (c >= 5 && c <= 7) ? 3'b100 : 3'b000;
            exp_q.push_back({3'b000, ep});
            tick(12'd630, 12'd700, (c < 10), 3'b111, (c == 8 || c == 9));
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs_v, exp_v;
        logic [2:0] ec, ep;
        int p;
        settle();
        // Minimum-spacing clicks, one per button, 2*DEBOUNCE+2 = 10 cycles apart
        for (int c = 0; c < 40; c++) begin
            p  = (c < 30) ? c / 10 : 2;
            ep = (c < 30 && (c % 10) >= 5) ? (3'b001 << p) : 3'b000;
            ec = (c >= 10 && (c % 10) == 0) ? (3'b001 << (c / 10 - 1)) : 3'b000;
            exp_q.push_back({ec, ep});
            tick(12'(400 + 120 * p), 12'd690, (c < 30) && ((c % 10) < 5), 3'b111, 1'b0);
            obs_v = {click, pressed};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL back_to_back c=%0d got click/pressed=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask

`ifdef BUTTON_HOVER_EN
    task automatic test_hover();
        logic [2:0] obs_v, exp_v;
        logic [11:0] x;
        settle();
        for (int c = 0; c < 12; c++) begin
            x = (c < 3) ? 12'd400 : (c < 6) ? 12'd500 : (c < 9) ? 12'd452 : 12'd400;
            if (c >= 1 && c <= 3)      hov_q.push_back(3'b001);
            else if (c >= 4 && c <= 6) hov_q.push_back(3'b010);
            else                       hov_q.push_back(3'b000);
            tick(x, 12'd690, 1'b0, (c < 9) ? 3'b111 : 3'b110, 1'b0);
            obs_v = hover;
            exp_v = hov_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL hover c=%0d got hover=%b want %b", c, obs_v, exp_v);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_click();
        test_drag_off();
        test_reenter();
        test_dead();
        test_glitch();
        test_disabled();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
`ifdef BUTTON_HOVER_EN
        test_hover();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
